// File: rtl/x_memburst.sv
// x_memburst: expands one burst command into single-byte memory requests and
// returns read bytes through a credit-limited FIFO.
module x_memburst #(
    parameter int RD_DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_accept,
    input  logic        i_cmd_rd_n_wr,
    input  logic [18:0] i_cmd_addr,
    input  logic [7:0]  i_cmd_len,
    input  logic        i_wr_valid,
    output logic        o_wr_accept,
    input  logic [7:0]  i_wr_data,
    output logic        o_rd_valid,
    input  logic        i_rd_accept,
    output logic [7:0]  o_rd_data,
    output logic        o_done,
    output logic        o_valid,
    input  logic        i_accept,
    output logic        o_rd_n_wr,
    output logic [18:0] o_addr,
    output logic [7:0]  o_wdata,
    input  logic        i_ready,
    input  logic [7:0]  i_rdata
);

    localparam int AW = $clog2(RD_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(RD_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [18:0]     addr_q;
    logic [7:0]      rem_q;
    logic            dir_q;
    logic [CW-1:0]   outstanding_q;
    logic [CW-1:0]   fifo_count_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [7:0]      fifo_mem [RD_DEPTH];

    logic [CW:0]     credit;
    logic            cmd_accept;
    logic            req_valid;
    logic            wr_accept;
    logic            done;
    logic            cmd_fire;
    logic            beat_fire;
    logic            issue;
    logic            cpl;
    logic            push;
    logic            pop;

    // Credit counts both bytes in flight and bytes parked in the FIFO, so a
    // read is only issued when its completion is guaranteed a FIFO slot.
    assign credit    = {1'b0, outstanding_q} + {1'b0, fifo_count_q};
    assign cpl       = i_ready & (outstanding_q != '0);
    assign push      = cpl;
    assign pop       = o_rd_valid & i_rd_accept;
    assign cmd_fire  = cmd_accept & i_cmd_valid;
    assign beat_fire = req_valid & i_accept;
    assign issue     = beat_fire & (state_q == S_RD);

    always_comb begin
        state_d    = state_q;
        cmd_accept = 1'b0;
        req_valid  = 1'b0;
        wr_accept  = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_accept = 1'b1;
                if (i_cmd_valid) begin
                    state_d = i_cmd_rd_n_wr ? S_RD : S_WR;
                end
            end
            S_WR: begin
                req_valid = i_wr_valid;
                wr_accept = i_accept;
                if (i_wr_valid && i_accept && (rem_q == 8'd0)) begin
                    state_d = S_DONE;
                end
            end
            S_RD: begin
                req_valid = (credit < DEPTH_W);
                if ((credit < DEPTH_W) && i_accept && (rem_q == 8'd0)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave as soon as the final completion lands, not a cycle later.
                if (outstanding_q == CW'(cpl)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            rem_q         <= '0;
            dir_q         <= 1'b0;
            outstanding_q <= '0;
            fifo_count_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q <= state_d;

            if (cmd_fire) begin
                addr_q <= i_cmd_addr;
                rem_q  <= i_cmd_len;
                dir_q  <= i_cmd_rd_n_wr;
            end else if (beat_fire) begin
                addr_q <= addr_q + 19'd1;
                rem_q  <= rem_q - 8'd1;
            end

            if (issue && !cpl) begin
                outstanding_q <= outstanding_q + CW'(1);
            end else if (!issue && cpl) begin
                outstanding_q <= outstanding_q - CW'(1);
            end

            if (push && !pop) begin
                fifo_count_q <= fifo_count_q + CW'(1);
            end else if (!push && pop) begin
                fifo_count_q <= fifo_count_q - CW'(1);
            end

            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= i_rdata;
        end
    end

    assign o_cmd_accept = cmd_accept & ~i_rst;
    assign o_valid      = req_valid & ~i_rst;
    assign o_wr_accept  = wr_accept & ~i_rst;
    assign o_done       = done & ~i_rst;
    assign o_rd_n_wr    = dir_q & ~i_rst;
    assign o_addr       = i_rst ? 19'd0 : addr_q;
    assign o_wdata      = ((state_q == S_WR) && !i_rst) ? i_wr_data : 8'd0;
    assign o_rd_valid   = (fifo_count_q != '0) & ~i_rst;
    assign o_rd_data    = o_rd_valid ? fifo_mem[rd_ptr_q] : 8'd0;

endmodule
